// File: rtl/tlatch.sv
// Per-bit toggle register: q[i] flips on rising clk when t[i]=1; synchronous rst clears all bits.
// Latency 1 clk from t to q; no backpressure, accepts t every cycle.
module tlatch #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] t,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q
);

  // Reset wins over toggle, so t may be unknown while rst is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: tb/tb_tlatch.sv
// Directed table-driven bench for tlatch (WIDTH=4 and default WIDTH=1 instances in lockstep).
// Inputs change on falling edges; outputs are sampled on the falling edge after each rising edge.
module tb_tlatch;

  logic       clk;
  logic       rst;
  logic [3:0] t;
  logic [0:0] t1;
  logic [3:0] q;
  logic [0:0] q1;

  int n_vec;
  int n_err;

  typedef struct {
    logic       rst;
    logic [3:0] t;
    logic [3:0] q;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  tlatch #(.WIDTH(4)) dut4 (
    .t   (t),
    .clk (clk),
    .rst (rst),
    .q   (q)
  );

  tlatch dut1 (
    .t   (t1),
    .clk (clk),
    .rst (rst),
    .q   (q1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (time %0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs now (on a falling edge), let one rising edge pass, return on the next falling edge.
  task automatic step(input logic r, input logic [3:0] tv);
    rst = r;
    t   = tv;
    t1  = tv[0:0];
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_both(input string name, input logic [3:0] exp);
    check({name, " w4"}, q, exp);
    check({name, " w1"}, {3'b000, q1}, {3'b000, exp[0]});
  endtask

  initial begin
    logic [3:0] model;
    n_vec = 0;
    n_err = 0;

    vecs[0]  = '{1'b1, 4'bxxxx, 4'b0000};  // reset with unknown t
    vecs[1]  = '{1'b0, 4'b0000, 4'b0000};  // hold
    vecs[2]  = '{1'b0, 4'b0000, 4'b0000};  // hold
    vecs[3]  = '{1'b0, 4'b0001, 4'b0001};  // single toggle
    vecs[4]  = '{1'b0, 4'b0000, 4'b0001};  // holds after toggle
    vecs[5]  = '{1'b1, 4'b0000, 4'b0000};
    vecs[6]  = '{1'b0, 4'b0001, 4'b0001};  // continuous toggle 1,0,1,0
    vecs[7]  = '{1'b0, 4'b0001, 4'b0000};
    vecs[8]  = '{1'b0, 4'b0001, 4'b0001};
    vecs[9]  = '{1'b0, 4'b0001, 4'b0000};
    vecs[10] = '{1'b0, 4'b0001, 4'b0001};
    vecs[11] = '{1'b1, 4'b0001, 4'b0000};  // reset beats toggle
    vecs[12] = '{1'b0, 4'b0001, 4'b0001};
    vecs[13] = '{1'b1, 4'b0000, 4'b0000};
    vecs[14] = '{1'b0, 4'b0101, 4'b0101};  // multi-bit
    vecs[15] = '{1'b0, 4'b0011, 4'b0110};
    vecs[16] = '{1'b0, 4'b1111, 4'b1001};
    vecs[17] = '{1'b0, 4'b1000, 4'b0001};
    vecs[18] = '{1'b0, 4'b0000, 4'b0001};
    vecs[19] = '{1'b1, 4'b1010, 4'b0000};

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].rst, vecs[i].t);
      check_both($sformatf("vec%0d", i), vecs[i].q);
    end

    // Reset pulse between edges must not clear q.
    step(1'b0, 4'b0101);
    check_both("preload", 4'b0101);
    t   = 4'b0000;
    t1  = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_both("rst_glitch", 4'b0101);

    // t pulse between edges must neither toggle nor reach q combinationally.
    t  = 4'b1111;
    t1 = 1'b1;
    #1 check_both("no_comb_path", 4'b0101);
    #1;
    t  = 4'b0000;
    t1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_both("t_glitch", 4'b0101);

    // Reset held high across a rising edge with t all ones.
    step(1'b1, 4'b1111);
    check_both("rst_all_t", 4'b0000);

    // Free-running clk/2 square wave on bits 3 and 0, bits 2:1 held.
    model = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 4'b1001);
      model = model ^ 4'b1001;
      check_both($sformatf("square%0d", k), model);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
